// File: rtl/bcd_scan_display.sv
// Four-digit scanned 7-segment display fed by a BCD sum via valid/ready.
// Optional leading-zero blanking under `BCD_SCAN_BLANK_EN.
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] bcd_in,
    input  logic        cout_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);

    logic [12:0]      disp;
    logic [12:0]      pend;
    logic             pend_valid;
    logic [1:0]       idx;
    logic [DIV_W-1:0] div;
    logic             div_end;
    logic             commit;
    logic             take;
    logic [3:0]       digit;
    logic             blank;

    assign div_end  = (div == DIV_W'(SCAN_DIV - 1));
    assign commit   = div_end && (idx == 2'd3) && pend_valid;
    assign in_ready = !pend_valid;
    assign take     = in_valid && in_ready;

    // take and commit are exclusive: take needs an empty pending slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            idx        <= 2'd0;
            div        <= '0;
        end else begin
            div <= div_end ? '0 : div + 1'b1;
            if (div_end)
                idx <= idx + 2'd1;
            if (take) begin
                pend       <= {cout_in, bcd_in};
                pend_valid <= 1'b1;
            end
            if (commit) begin
                disp       <= pend;
                pend_valid <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1111001;
        endcase
        return s;
    endfunction

    always_comb begin
        digit = disp[3:0];
        unique case (idx)
            2'd0: digit = disp[3:0];
            2'd1: digit = disp[7:4];
            2'd2: digit = disp[11:8];
            2'd3: digit = {3'b000, disp[12]};
        endcase
    end

`ifdef BCD_SCAN_BLANK_EN
    // a digit blanks only when it and every higher digit are zero
    always_comb begin
        blank = 1'b0;
        unique case (idx)
            2'd0: blank = 1'b0;
            2'd1: blank = !disp[12] && (disp[11:4] == 8'd0);
            2'd2: blank = !disp[12] && (disp[11:8] == 4'd0);
            2'd3: blank = !disp[12];
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign an  = 4'b0001 << idx;
    assign seg = blank ? 7'b0000000 : seg7(digit);
    assign err = (disp[3:0] > 4'd9) || (disp[7:4] > 4'd9)
              || (disp[11:8] > 4'd9);

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized scoreboard bench for bcd_scan_display (SCAN_DIV=4).
// Model tracks elapsed cycles and a pending queue; a monitor compares outputs.
module tb_bcd_scan_display;

    localparam int SD = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        cout_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;

    bcd_scan_display #(.SCAN_DIV(SD), .DIV_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .cout_in(cout_in), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] m_disp;
    int          t;
    int          acc_n = 0;
    bit          armed = 0;
    logic [6:0]  code[16];

    initial begin
        code[0] = 7'b0111111; code[1] = 7'b0000110;
        code[2] = 7'b1011011; code[3] = 7'b1001111;
        code[4] = 7'b1100110; code[5] = 7'b1101101;
        code[6] = 7'b1111101; code[7] = 7'b0000111;
        code[8] = 7'b1111111; code[9] = 7'b1101111;
        for (int i = 10; i < 16; i++) code[i] = 7'b1111001;
    end

    // Reference: value accepted while slot empty, shown at the frame's last edge
    always @(posedge clk) begin
        bit had;
        if (!rst_n) begin
            t = 0;
            m_disp = '0;
            exp_q.delete();
            armed = 1;
        end else if (armed) begin
            had = (exp_q.size() != 0);
            if (had && (t % FR) == FR - 1)
                m_disp = exp_q.pop_front();
            if (in_valid && !had) begin
                exp_q.push_back({cout_in, bcd_in});
                acc_n++;
            end
            t++;
        end
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s t=%0d disp=%h got=%b want=%b", nm, t, m_disp, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int k;
        logic [3:0] d[4];
        logic [6:0] es;
        bit ee;
        if (armed) begin
            k = (t / SD) % 4;
            d[0] = m_disp[3:0];
            d[1] = m_disp[7:4];
            d[2] = m_disp[11:8];
            d[3] = {3'b000, m_disp[12]};
            es = code[d[k]];
`ifdef BCD_SCAN_BLANK_EN
            if (k > 0) begin
                bit z = 1;
                for (int j = k; j < 4; j++) if (d[j] != 0) z = 0;
                if (z) es = 7'b0000000;
            end
`endif
            ee = (d[0] > 9) || (d[1] > 9) || (d[2] > 9);
            chk("an", {3'b000, an}, 7'(4'b0001 << k));
            chk("seg", seg, es);
            chk("err", {6'b0, err}, {6'b0, ee});
            chk("in_ready", {6'b0, in_ready}, {6'b0, exp_q.size() == 0});
        end
    end

    task automatic send(input logic [12:0] v);
        int n0 = acc_n;
        int w = 0;
        cout_in = v[12];
        bcd_in = v[11:0];
        in_valid = 1'b1;
        while (acc_n == n0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc_n == n0) begin
            errors++;
            $display("FAIL accept_timeout value=%h waited=%0d", v, w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        logic [12:0] v;
        rst_n = 1'b0;
        in_valid = 1'b0;
        bcd_in = '0;
        cout_in = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(FR + 3);

        send(13'h0505);
        send(13'h1024);
        send(13'h0346);
        send(13'h03A6);
        send(13'h0159);
        idle(2 * FR);

        send(13'h0999);
        w = 0;
        while (((t / SD) % 4) != 2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(FR + 5);

        for (int i = 0; i < 25; i++) begin
            v[3:0]  = 4'($urandom_range(0, 11));
            v[7:4]  = 4'($urandom_range(0, 11));
            v[11:8] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
            v[12]   = 1'($urandom_range(0, 1));
            if (i % 5 == 0) v = {1'b0, 8'h00, v[3:0]};
            send(v);
            idle($urandom_range(0, 20));
        end
        idle(2 * FR + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the 3-digit BCD adder.
- Accepts the adder's 12-bit packed BCD sum plus carry-out through a valid/ready handshake, and holds it in a pending register.
- Commits the pending value to the display register only at a scan-frame boundary, so the display never tears.
- Time-multiplexes the resulting 4 digits (carry = thousands digit) onto one 7-segment bus with one-hot digit enables.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range >= 2; frame = 4*SCAN_DIV cycles
DIV_W, 16, width of divider counter; must satisfy 2**DIV_W >= SCAN_DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  bcd_in/cout_in valid
in_ready  output  1  block can accept a new value
bcd_in  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units
cout_in  input  1  adder carry-out, displayed as thousands digit (0/1)
seg  output  7  segment drive, active-high, bit0=a .. bit6=g
an  output  4  one-hot digit enable, active-high, an[0]=units .. an[3]=thousands
err  output  1  displayed value contains a non-BCD digit (>9)

Behaviour:
- One clock, clk. Reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset values:
  - Registers: disp=0, pending_valid=0, pending data=0, idx=0, div=0.
  - Outputs: in_ready=1, an=4'b0001, seg=7'b0111111 ('0'), err=0.
- Reset mid-operation discards any pending value; no partial commit.
- Handshake:
  - Transfer occurs on an edge where in_valid && in_ready.
  - in_ready = !pending_valid, a registered-state decode.
  - On transfer: pending <= {cout_in,bcd_in}; pending_valid <= 1.
  - in_valid held while in_ready=0 is not consumed. The source holds data until accepted.
- Divider and scan:
  - div counts 0..SCAN_DIV-1 and wraps to 0.
  - At div==SCAN_DIV-1: idx <= idx+1 (2 bits, 3->0 wrap).
- Commit:
  - Condition: idx==3 && div==SCAN_DIV-1 && pending_valid.
  - On that edge: disp <= pending; pending_valid <= 0; in_ready=1 from the next cycle.
  - A value accepted on the commit edge itself is impossible, because in_ready=0 while pending.
- Latency: accept-to-visible is between 1 and 4*SCAN_DIV cycles. The first displayed digit is always units (idx 0).
- Outputs are combinational decodes of the registers:
  - an = 1<<idx.
  - seg = 7-seg code of disp digit[idx]. Digit 3 = {3'b0, disp_cout}.
- Segment codes:
  - Digits 0-9: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Digit values 10-15 show 'E'=1111001.
- err = any of the 3 disp BCD digits > 9. It updates only on commit.

Optional Feature:
- Macro: BCD_SCAN_BLANK_EN.
- Defined: leading-zero blanking. Digit k (k=1..3) drives seg=0 while an stays asserted, when digit k and all higher digits are zero.
  - Units digit is never blanked.
  - An 'E' digit counts as nonzero.
- Undefined: all 4 digits are always decoded. No blanking logic is synthesized.

Test Plan:
All scenarios use SCAN_DIV=4.
- Reset: hold rst_n=0 for 2 clk -> an=0001, seg=0111111, in_ready=1, err=0. an rotates 0001->0010->0100->1000 every 4 cycles; the cycle after the 16-cycle frame shows 0001.
- Load 505: bcd_in=12'h505, cout_in=0, one-cycle in_valid -> in_ready=0 until frame wrap. Next frame seg sequence is 1101101, 0111111, 1101101, then:
  - macro undefined: 0111111;
  - macro defined: 0000000.
- Load 1024: bcd_in=12'h024, cout_in=1 -> after commit, frame shows 4(1100110), 2(1011011), 0(0111111 even with blanking), 1(0000110).
- Backpressure: with a value pending, hold in_valid=1 with 12'h346 -> no transfer while in_ready=0. Transfer occurs the cycle after commit; the following frame shows 6,4,3,0.
- Invalid digit: load 12'h3A6 -> tens digit shows 1111001 and err=1 after commit. Then load 12'h159 -> err=0 after its commit, frame shows 9,5,1.
- Reset mid-frame: pending 12'h999 accepted, then rst_n=0 at idx=2 -> full reset values. 999 is never displayed, and in_ready=1.
